uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bus: the line input plus the received byte, strobe and status.
// The receiver connects through "slave"; the serial line driver connects through "master".
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input rx_data, rx_done, frame_err, busy);
  modport slave  (input rx, output rx_data, rx_done, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. A falling edge on the synchronized line
// starts a frame; each bit is sampled once, at its midpoint.
module uart_rx #(
  parameter int unsigned SYS_CLK    = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);

  localparam int unsigned TICK_DIV = SYS_CLK / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned IDX_W    = 3;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_sync1;
  logic              r_rx_s;
  logic              r_rx_prev;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_done;
  logic              r_frame_err;
  logic              r_busy;

  logic w_tick;
  logic w_fall;
  logic w_at_mid;
  logic w_at_last;
  logic w_div_clr;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_load;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_fall    = r_rx_prev & ~r_rx_s;
  assign w_at_mid  = w_tick && (r_tick_cnt == MID_TICK);
  assign w_at_last = w_tick && (r_tick_cnt == LAST_TICK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_fall)    w_state_next = START;
      START: if (w_at_mid)  w_state_next = r_rx_s ? IDLE : DATA;
      DATA:  if (w_at_last && (r_bit_idx == LAST_BIT)) w_state_next = STOP;
      STOP:  if (w_at_last) w_state_next = IDLE;
      default:              w_state_next = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    w_div_clr  = 1'b0;
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_div_clr = w_fall;
        w_cnt_clr = w_fall;
      end
      START:   w_cnt_clr  = w_at_mid;
      DATA:    w_shift_en = w_at_last;
      STOP:    w_load     = w_at_last;
      default: w_cnt_clr  = 1'b0;
    endcase
  end

  // Synchronizer, dividers, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_div       <= '0;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sync1   <= bus.rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;

      if (w_div_clr || w_tick) r_div <= '0;
      else                     r_div <= r_div + DIV_W'(1);

      if (w_cnt_clr)   r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= r_tick_cnt + CNT_W'(1);

      if (w_cnt_clr)       r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + IDX_W'(1);

      if (w_shift_en) r_shift <= {r_rx_s, r_shift[BYTE_W-1:1]};

      r_rx_done <= w_load;
      if (w_load) begin
        r_rx_data   <= r_shift;
        r_frame_err <= ~r_rx_s;
      end

      r_busy <= (w_state_next != IDLE);
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_done   = r_rx_done;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at SYS_CLK=1.6 MHz, BAUD=10k (10 clk per tick, 160 clk per bit).
module tb_uart_rx;

  localparam int BIT_CLK   = 160;
  localparam int FRAME_CLK = 10 * BIT_CLK;
  localparam int LAT_LO    = 1517;
  localparam int LAT_HI    = 1523;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       fe;
  } done_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_wide = 0;
  int   n_hold = 0;
  int   t_start = 0;

  done_t      q[$];
  logic       done_prev;
  logic       rst_prev;
  logic [7:0] data_prev;
  logic       fe_prev;
  vec_t       vecs[7];

  uart_rx_if bus ();

  uart_rx #(.SYS_CLK(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Done-event recorder plus strobe-width and output-hold watchers
  always @(negedge clk) begin
    if (bus.rx_done) q.push_back('{cyc, bus.rx_data, bus.frame_err});
    if (bus.rx_done && done_prev) n_wide <= n_wide + 1;
    if (!rst && !rst_prev && !bus.rx_done &&
        ((bus.rx_data !== data_prev) || (bus.frame_err !== fe_prev)))
      n_hold <= n_hold + 1;
    done_prev <= bus.rx_done;
    rst_prev  <= rst;
    data_prev <= bus.rx_data;
    fe_prev   <= bus.frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a negedge; returns at a negedge after the full stop bit
  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_start = cyc;
    bus.rx = 1'b0;
    idle(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      idle(BIT_CLK);
    end
    bus.rx = stop;
    idle(BIT_CLK);
  endtask

  task automatic expect_one(input string name, input logic [7:0] exp_d, input logic exp_fe, input int t0);
    done_t ev;
    int    lat;
    chk({name, "_done_count"}, 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      ev  = q.pop_front();
      lat = ev.cyc - t0;
      chk({name, "_data"}, 32'(ev.data), 32'(exp_d));
      chk({name, "_frame_err"}, 32'(ev.fe), 32'(exp_fe));
      n_vec++;
      if (lat < LAT_LO || lat > LAT_HI) begin
        n_err++;
        $display("FAIL %s_latency: got %0d clk, expected %0d..%0d", name, lat, LAT_LO, LAT_HI);
      end
    end
    q.delete();
  endtask

  initial begin
    done_t e0;
    done_t e1;
    int    t_a;
    int    t_b;

    vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
    vecs[2] = '{8'h0F, 1'b1, 8'h0F, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 8'h80, 1'b1};
    vecs[6] = '{8'h01, 1'b1, 8'h01, 1'b0};

    rst    = 1'b1;
    bus.rx = 1'b1;
    idle(4);
    chk("reset_rx_data",   32'(bus.rx_data),   32'h00);
    chk("reset_rx_done",   32'(bus.rx_done),   32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset_busy",      32'(bus.busy),      32'd0);
    rst = 1'b0;
    idle(20);

    // Table of isolated frames with idle gaps
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      bus.rx = 1'b1;
      idle(20);
      expect_one($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_fe, t_start);
      chk($sformatf("vec%0d_busy_idle", v), 32'(bus.busy), 32'd0);
      chk($sformatf("vec%0d_hold_data", v), 32'(bus.rx_data), 32'(vecs[v].exp_data));
    end

    // Short low glitch: aborts at mid start bit, no output change
    bus.rx = 1'b0;
    idle(10);
    chk("glitch_busy_high", 32'(bus.busy), 32'd1);
    idle(20);
    bus.rx = 1'b1;
    idle(120);
    chk("glitch_busy_low",  32'(bus.busy), 32'd0);
    chk("glitch_no_done",   32'(q.size()), 32'd0);
    chk("glitch_data_kept", 32'(bus.rx_data), 32'h01);
    q.delete();

    // Back-to-back frames, no idle between stop and next start
    t_a = cyc;
    send_frame(8'hA3, 1'b1);
    t_b = cyc;
    send_frame(8'h0F, 1'b1);
    bus.rx = 1'b1;
    idle(20);
    chk("b2b_done_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      e0 = q.pop_front();
      e1 = q.pop_front();
      chk("b2b_first_data",  32'(e0.data), 32'hA3);
      chk("b2b_second_data", 32'(e1.data), 32'h0F);
      chk("b2b_spacing",     32'(e1.cyc - e0.cyc), 32'd1600);
      chk("b2b_first_fe",    32'(e0.fe), 32'd0);
      chk("b2b_start_gap",   32'(t_b - t_a), 32'd1600);
    end
    q.delete();

    // Reset during bit 4 of 0xFF aborts the frame
    bus.rx = 1'b0;
    idle(BIT_CLK);
    bus.rx = 1'b1;
    idle(4 * BIT_CLK + 80);
    rst = 1'b1;
    idle(3);
    chk("midrst_rx_data",   32'(bus.rx_data),   32'h00);
    chk("midrst_rx_done",   32'(bus.rx_done),   32'd0);
    chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    rst = 1'b0;
    idle(3 * BIT_CLK + 80 + BIT_CLK);
    chk("midrst_no_done", 32'(q.size()), 32'd0);
    q.delete();
    send_frame(8'h3C, 1'b1);
    idle(20);
    expect_one("after_rst", 8'h3C, 1'b0, t_start);

    // Stop bit low then a long line break: one frame only
    send_frame(8'hC5, 1'b0);
    idle(3 * FRAME_CLK);
    chk("break_busy", 32'(bus.busy), 32'd0);
    expect_one("break", 8'hC5, 1'b1, t_start);
    bus.rx = 1'b1;
    idle(50);
    chk("break_no_extra", 32'(q.size()), 32'd0);
    send_frame(8'h81, 1'b1);
    idle(20);
    expect_one("post_break", 8'h81, 1'b0, t_start);

    chk("rx_done_width", 32'(n_wide), 32'd0);
    chk("output_hold",   32'(n_hold), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
